ysyx_22050550_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the decode stage. Owns the PC, issues one

---
 rtl/ysyx_22050550_fetch_pkg.sv | 14 +
 rtl/ysyx_22050550_fetch_buf.sv | 62 ++++++
 rtl/ysyx_22050550_fetch.sv | 142 ++++++++++++++
 tb/tb_ysyx_22050550_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_fetch_pkg.sv
// Shared constants for the instruction fetch stage.
// Default widths, reset PC, buffer depth and fetch FSM state encodings.
package ysyx_22050550_fetch_pkg;

  localparam int DEF_PC_WIDTH   = 64;
  localparam int DEF_INST_WIDTH = 32;
  localparam int DEF_BUF_DEPTH  = 2;

  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

  localparam logic [0:0] FETCH_REQ  = 1'b0;
  localparam logic [0:0] FETCH_WAIT = 1'b1;

endpackage

// File: rtl/ysyx_22050550_fetch_buf.sv
// Synchronous FIFO of {pc,instr} pairs; flush beats push, pop with full is honoured.
// Ports: clk, rst_n, flush, push, push_data, pop, head_data, count, full, empty.
module ysyx_22050550_fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 96,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ysyx_22050550_fetch.sv
// Fetch stage: owns the PC, one imem read in flight, buffers {pc,instr} for decode.
// Ports: redirect_*, imem_req_*, imem_rsp_*, pc_o/instr_o/valid_o/ready_i;
// perf_fetch_o/perf_stall_o only with YSYX_22050550_FETCH_PERF_EN.
module ysyx_22050550_fetch
  import ysyx_22050550_fetch_pkg::*;
#(
  parameter int                      PC_WIDTH   = DEF_PC_WIDTH,
  parameter int                      INST_WIDTH = DEF_INST_WIDTH,
  parameter logic [PC_WIDTH-1:0]     RESET_PC   = PC_WIDTH'(DEF_RESET_PC),
  parameter int                      BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [PC_WIDTH-1:0]   imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [INST_WIDTH-1:0] instr_o,
  output logic                  valid_o,
  input  logic                  ready_i
`ifdef YSYX_22050550_FETCH_PERF_EN
  ,
  output logic [63:0]           perf_fetch_o,
  output logic [63:0]           perf_stall_o
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [0:0]          state;
  logic                active;
  logic                drop;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] tag_pc;

  logic [CW-1:0]       count;
  logic [CW:0]         occ;
  logic                full;
  logic                empty;
  logic                wait_st;
  logic                accept;
  logic                push;
  logic                pop;

  assign wait_st = (state == FETCH_WAIT);
  // Slots already claimed: buffered entries plus the one in flight.
  assign occ     = {1'b0, count} + (CW + 1)'(wait_st);

  // active keeps req_valid low while reset is asserted.
  assign imem_req_valid_o = active && !wait_st && !full &&
                            (occ < (CW + 1)'(BUF_DEPTH));
  assign imem_req_addr_o  = fetch_pc;

  assign accept  = imem_req_valid_o && imem_req_ready_i;
  assign push    = wait_st && imem_rsp_valid_i &&
                   !drop && !redirect_valid_i;
  assign valid_o = !empty;
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_REQ;
      active   <= 1'b0;
      drop     <= 1'b0;
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
    end else begin
      active <= 1'b1;

      if (redirect_valid_i) begin
        fetch_pc <= redirect_pc_i;
      end else if (accept) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
      end

      if (accept) begin
        tag_pc <= fetch_pc;
      end

      // A redirect never changes the state flow; it only marks the
      // in-flight response (or the one accepted this edge) as stale.
      case (state)
        FETCH_REQ: begin
          if (accept) begin
            state <= FETCH_WAIT;
          end
          drop <= accept && redirect_valid_i;
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid_i) begin
            state <= FETCH_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= drop || redirect_valid_i;
          end
        end
        default: begin
          state <= FETCH_REQ;
          drop  <= 1'b0;
        end
      endcase
    end
  end

  ysyx_22050550_fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (PC_WIDTH + INST_WIDTH),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid_i),
    .push      (push),
    .push_data ({tag_pc, imem_rsp_data_i}),
    .pop       (pop),
    .head_data ({pc_o, instr_o}),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

`ifdef YSYX_22050550_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (push) begin
        perf_fetch_o <= perf_fetch_o + 64'd1;
      end
      if (!valid_o) begin
        perf_stall_o <= perf_stall_o + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050550_fetch.sv
// Directed bench for the fetch stage with a small latency-programmable imem model.
// Each scenario task checks its own hand-computed expectations.
module tb_ysyx_22050550_fetch;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
`ifdef YSYX_22050550_FETCH_PERF_EN
  logic [63:0] perf_fetch_o;
  logic [63:0] perf_stall_o;
`endif

  logic        mem_auto = 1'b0;
  int          lat = 1;
  logic        t_rsp_valid = 1'b0;
  logic [31:0] t_rsp_data = '0;
  logic        m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_data = '0;

  assign imem_rsp_valid_i = mem_auto ? m_rsp_valid : t_rsp_valid;
  assign imem_rsp_data_i  = mem_auto ? m_rsp_data  : t_rsp_data;

  ent_t        seen[$];
  logic [63:0] acc[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          stall_cnt = 0;

  int checks = 0;
  int errors = 0;
  int sb, ab, st0;

  ysyx_22050550_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .pc_o             (pc_o),
    .instr_o          (instr_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i)
`ifdef YSYX_22050550_FETCH_PERF_EN
    ,
    .perf_fetch_o     (perf_fetch_o),
    .perf_stall_o     (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] a2i(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Handshake monitor: records consumed entries and accepted requests.
  always @(posedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) begin
        seen.push_back('{pc: pc_o, instr: instr_o});
        pop_cyc.push_back(cyc);
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        acc.push_back(imem_req_addr_o);
      end
      if (!valid_o) begin
        stall_cnt++;
      end
    end
    cyc++;
  end

  // Instruction memory model: response 'lat' cycles after acceptance.
  logic        m_acc;
  logic [63:0] m_addr;
  logic        m_pend = 1'b0;
  logic [63:0] m_pend_addr = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    m_acc  = imem_req_valid_o && imem_req_ready_i;
    m_addr = imem_req_addr_o;
    #1;
    m_rsp_valid = 1'b0;
    if (!mem_auto) begin
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = a2i(m_pend_addr);
          m_pend      = 1'b0;
        end
      end
      if (m_acc) begin
        if (lat <= 1) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = a2i(m_addr);
        end else begin
          m_pend      = 1'b1;
          m_pend_addr = m_addr;
          m_cnt       = lat - 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    mem_auto = 1'b0;
    t_rsp_valid = 1'b0;
    lat = 1;
    tick();
    tick();
    sb  = seen.size();
    ab  = acc.size();
    st0 = stall_cnt;
    rst_n = 1'b1;
  endtask

  task automatic wait_seen(input int n, input string nm);
    for (int i = 0; i < 60 && seen.size() < n; i++) tick();
    checks++;
    if (seen.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d entries, need %0d", nm, seen.size(), n);
    end
  endtask

  task automatic wait_acc(input int n, input string nm);
    for (int i = 0; i < 60 && acc.size() < n; i++) tick();
    checks++;
    if (acc.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d reqs, need %0d", nm, acc.size(), n);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ready_i = 1'b0;
    tick();
    chk("reset valid_o", 64'(valid_o), 64'd0);
    chk("reset req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("reset req_addr", imem_req_addr_o, 64'h8000_0000);
    chk("reset pc_o", pc_o, 64'd0);
    chk("reset instr_o", 64'(instr_o), 64'd0);
  endtask

  task automatic test_stream;
    do_reset();
    ready_i = 1'b1;
    mem_auto = 1'b1;
    lat = 1;
    wait_seen(sb + 3, "stream");
    if (seen.size() >= sb + 3) begin
      chk("stream acc0", acc[ab], 64'h8000_0000);
      chk("stream acc1", acc[ab + 1], 64'h8000_0004);
      chk("stream acc2", acc[ab + 2], 64'h8000_0008);
      chk("stream pc0", seen[sb].pc, 64'h8000_0000);
      chk("stream in0", 64'(seen[sb].instr), 64'h9357_9BDF);
      chk("stream pc1", seen[sb + 1].pc, 64'h8000_0004);
      chk("stream in1", 64'(seen[sb + 1].instr), 64'h9357_9BDB);
      chk("stream pc2", seen[sb + 2].pc, 64'h8000_0008);
      chk("stream in2", 64'(seen[sb + 2].instr), 64'h9357_9BD7);
      chk("stream gap01", 64'(pop_cyc[sb + 1] - pop_cyc[sb]), 64'd2);
      chk("stream gap12", 64'(pop_cyc[sb + 2] - pop_cyc[sb + 1]), 64'd2);
    end
  endtask

  task automatic test_stall;
    do_reset();
    ready_i = 1'b0;
    mem_auto = 1'b1;
    lat = 1;
    repeat (10) tick();
    chk("stall reqs", 64'(acc.size() - ab), 64'd2);
    chk("stall valid_o", 64'(valid_o), 64'd1);
    chk("stall req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("stall head pc", pc_o, 64'h8000_0000);
    ready_i = 1'b1;
    wait_seen(sb + 4, "stall drain");
    if (seen.size() >= sb + 4) begin
      chk("drain pc0", seen[sb].pc, 64'h8000_0000);
      chk("drain pc1", seen[sb + 1].pc, 64'h8000_0004);
      chk("drain in1", 64'(seen[sb + 1].instr), 64'h9357_9BDB);
      chk("drain pc2", seen[sb + 2].pc, 64'h8000_0008);
      chk("drain pc3", seen[sb + 3].pc, 64'h8000_000C);
    end
  endtask

  task automatic test_redirect_drop;
    int s0, a0;
    do_reset();
    ready_i = 1'b1;
    mem_auto = 1'b1;
    lat = 3;
    wait_acc(ab + 3, "redir pre");
    chk("redir acc2", acc[ab + 2], 64'h8000_0008);
    s0 = seen.size();
    a0 = acc.size();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h8000_0100;
    tick();
    redirect_valid_i = 1'b0;
    chk("redir req_valid during drop", 64'(imem_req_valid_o), 64'd0);
    wait_seen(s0 + 1, "redir post");
    if (seen.size() > s0 && acc.size() > a0) begin
      chk("redir next req", acc[a0], 64'h8000_0100);
      chk("redir first pc", seen[s0].pc, 64'h8000_0100);
      chk("redir first in", 64'(seen[s0].instr), 64'h9357_9ADF);
    end
  endtask

  task automatic test_redirect_same_cycle;
    int s0;
    do_reset();
    ready_i = 1'b0;
    wait_acc(ab + 1, "same req0");
    t_rsp_valid = 1'b1;
    t_rsp_data = 32'h0000_0013;
    tick();
    t_rsp_valid = 1'b0;
    wait_acc(ab + 2, "same req1");
    chk("same head valid", 64'(valid_o), 64'd1);
    chk("same head instr", 64'(instr_o), 64'h0000_0013);
    s0 = seen.size();
    t_rsp_valid = 1'b1;
    t_rsp_data = 32'hDEAD_BEEF;
    ready_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h8000_0200;
    tick();
    t_rsp_valid = 1'b0;
    ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    chk("same pop count", 64'(seen.size() - s0), 64'd1);
    if (seen.size() > s0) chk("same pop pc", seen[s0].pc, 64'h8000_0000);
    chk("same valid_o", 64'(valid_o), 64'd0);
    chk("same req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("same req_addr", imem_req_addr_o, 64'h8000_0200);
    tick();
    chk("same still empty", 64'(valid_o), 64'd0);
  endtask

  task automatic test_reset_mid_wait;
    int a2;
    do_reset();
    ready_i = 1'b1;
    wait_acc(ab + 1, "rstw req");
    chk("rstw in wait", 64'(imem_req_valid_o), 64'd0);
    rst_n = 1'b0;
    tick();
    tick();
    a2 = acc.size();
    rst_n = 1'b1;
    t_rsp_valid = 1'b1;
    t_rsp_data = 32'h0BAD_0BAD;
    tick();
    t_rsp_valid = 1'b0;
    chk("rstw rsp ignored", 64'(valid_o), 64'd0);
    wait_acc(a2 + 1, "rstw first req");
    if (acc.size() > a2) chk("rstw first addr", acc[a2], 64'h8000_0000);
    tick();
    chk("rstw still empty", 64'(valid_o), 64'd0);
  endtask

  task automatic test_wrap;
    do_reset();
    ready_i = 1'b1;
    mem_auto = 1'b1;
    lat = 1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    wait_seen(sb + 2, "wrap");
    if (seen.size() >= sb + 2) begin
      chk("wrap acc0", acc[ab], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap acc1", acc[ab + 1], 64'h0);
      chk("wrap pc0", seen[sb].pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap in0", 64'(seen[sb].instr), 64'hECA8_6423);
      chk("wrap pc1", seen[sb + 1].pc, 64'h0);
      chk("wrap in1", 64'(seen[sb + 1].instr), 64'h1357_9BDF);
    end
    imem_req_ready_i = 1'b0;
    repeat (6) tick();
    chk("wrap drained", 64'(valid_o), 64'd0);
`ifdef YSYX_22050550_FETCH_PERF_EN
    chk("perf fetch", perf_fetch_o, 64'(seen.size() - sb));
    chk("perf stall", perf_stall_o, 64'(stall_cnt - st0));
`endif
    imem_req_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_reset_mid_wait();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
